// File: rtl/serial_pkg.sv
// Shared definitions for the serializer and the bit-stream sequence detectors.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int DEF_WIDTH = 8;

  // Detector output levels, kept here so every detector agrees on polarity.
  localparam logic found    = 1'b1;
  localparam logic notfound = 1'b0;

endpackage

// File: rtl/bit_serializer_hold_reg.sv
// One-word holding register that lets the next word wait while the current
// word is still being shifted out.
module bit_serializer_hold_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] pend,
  output logic             pend_full
);

  // A load always wins over a drain so a refill on the drain edge stays full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (load) begin
      pend      <= data_in;
      pend_full <= 1'b1;
    end else if (drain) begin
      pend_full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits one bit per unheld cycle on x_out for the sequence detectors.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             x_out,
  output logic             bit_valid,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       next_state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend;
  logic             pend_full;
  logic             accept;
  logic             load_direct;
  logic             load_pend;
  logic             drain;
  logic             shift_en;
  logic             at_last;
  logic             x_bit;

  // Ready depends only on the holding flag, never on hold or the drain edge.
  assign load_ready = !pend_full;
  assign accept     = load_valid && load_ready;
  assign load_pend  = accept && !load_direct;
  assign at_last    = (cnt == LAST_CNT);

  // The outgoing bit always sits at one end of sreg; shifting moves the next one in.
  assign x_bit        = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  bit_serializer_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load_pend),
    .drain    (drain),
    .data_in  (data_in),
    .pend     (pend),
    .pend_full(pend_full)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, word routing and serial outputs from registered state and hold.
  always_comb begin
    next_state  = state;
    bit_valid   = 1'b0;
    x_out       = 1'b0;
    last_bit    = 1'b0;
    shift_en    = 1'b0;
    load_direct = 1'b0;
    drain       = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !pend_full) begin
          load_direct = 1'b1;
          next_state  = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          bit_valid = 1'b1;
          x_out     = x_bit;
          shift_en  = 1'b1;
          if (at_last) begin
            last_bit = 1'b1;
            if (pend_full) begin
              drain = 1'b1;
            end else if (accept) begin
              load_direct = 1'b1;
            end else begin
              next_state = IDLE;
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift register and bit counter; a fresh word restarts the count at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load_direct) begin
      sreg <= data_in;
      cnt  <= '0;
    end else if (drain) begin
      sreg <= pend;
      cnt  <= '0;
    end else if (shift_en) begin
      sreg <= sreg_shifted;
      cnt  <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (MSB-first and LSB-first).
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       hold;

  logic       load_ready, x_out, bit_valid, last_bit;
  logic       load_ready_l, x_out_l, bit_valid_l, last_bit_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .hold      (hold),
    .x_out     (x_out),
    .bit_valid (bit_valid),
    .last_bit  (last_bit)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .load_valid(load_valid),
    .load_ready(load_ready_l),
    .hold      (hold),
    .x_out     (x_out_l),
    .bit_valid (bit_valid_l),
    .last_bit  (last_bit_l)
  );

  task automatic check_output(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic lv, input logic [7:0] d, input logic h);
    load_valid = lv;
    data_in    = d;
    hold       = h;
  endtask

  // Drive one cycle's inputs, check that cycle's outputs, advance past the edge.
  task automatic step(input string tag, input logic lv, input logic [7:0] d, input logic h,
                      input logic use_lsb, input logic ev, input logic ex,
                      input logic el, input logic er);
    apply_stimulus(lv, d, h);
    #1;
    check_output({tag, " bit_valid"},  use_lsb ? bit_valid_l  : bit_valid,  ev);
    check_output({tag, " x_out"},      use_lsb ? x_out_l      : x_out,      ex);
    check_output({tag, " last_bit"},   use_lsb ? last_bit_l   : last_bit,   el);
    check_output({tag, " load_ready"}, use_lsb ? load_ready_l : load_ready, er);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  p8;
    logic [15:0] s16;
    logic [23:0] s24;
    logic [9:0]  hx, hbv, hl;

    reset = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b0);
    #1;
    check_output("reset x_out",      x_out,      1'b0);
    check_output("reset bit_valid",  bit_valid,  1'b0);
    check_output("reset last_bit",   last_bit,   1'b0);
    check_output("reset load_ready", load_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] single word 96 msb first");
    p8 = 8'b1001_0110;
    step("w96 idle", 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step($sformatf("w96 c%0d", i + 1), 1'b0, 8'h00, 1'b0, 1'b0,
           1'b1, p8[7-i], (i == 7), 1'b1);

    $display("[TB] back to back A5 3C");
    s16 = 16'hA53C;
    step("b2b idle", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      step($sformatf("b2b c%0d", i + 1), (i == 0), 8'h3C, 1'b0, 1'b0,
           1'b1, s16[15-i], (i == 7 || i == 15), (i == 0 || i >= 8));

    $display("[TB] three words offered continuously");
    s24 = 24'hC35A0F;
    step("three idle", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++)
      step($sformatf("three c%0d", i + 1), (i <= 8),
           (i == 0) ? 8'h5A : ((i <= 8) ? 8'h0F : 8'h00), 1'b0, 1'b0,
           1'b1, s24[23-i], (i == 7 || i == 15 || i == 23),
           (i == 0 || i == 8 || i >= 16));

    $display("[TB] F0 with hold in cycles 3 and 4");
    hx  = 10'b1100110000;
    hbv = 10'b1100111111;
    hl  = 10'b0000000001;
    step("hold idle", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 10; c++)
      step($sformatf("hold c%0d", c), 1'b0, 8'h00, (c == 3 || c == 4), 1'b0,
           hbv[10-c], hx[10-c], hl[10-c], 1'b1);

    $display("[TB] reset during FF with word pending");
    step("rst idle", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rst c1", 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("rst c2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("rst c3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    #1;
    check_output("rst c4 pre bit_valid",  bit_valid,  1'b1);
    check_output("rst c4 pre load_ready", load_ready, 1'b0);
    reset = 1'b0;
    #1;
    check_output("rst async x_out",      x_out,      1'b0);
    check_output("rst async bit_valid",  bit_valid,  1'b0);
    check_output("rst async last_bit",   last_bit,   1'b0);
    check_output("rst async load_ready", load_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    p8 = 8'h81;
    step("post idle", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step($sformatf("post c%0d", i + 1), 1'b0, 8'h00, 1'b0, 1'b0,
           1'b1, p8[7-i], (i == 7), 1'b1);

    $display("[TB] lsb first 09");
    p8 = 8'b1001_0000;
    step("lsb idle", 1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step($sformatf("lsb c%0d", i + 1), 1'b0, 8'h00, 1'b0, 1'b1,
           1'b1, p8[7-i], (i == 7), 1'b1);
    step("lsb end idle", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
